// File: rtl/lsu_multi_outstanding.sv
// Load/store unit with a pending-response FIFO; byte-lane alignment, misalign/bus-error reporting, flush squash.
// Optional macro LSU_PERF_CNT_EN adds load/store/stall performance counters.
package lsu_pkg;
    typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} fu_op_t;

    localparam int unsigned WB_ID_W = 5;

    typedef struct packed {
        logic               wb_vld;
        logic [31:0]        wb_data;
        logic [WB_ID_W-1:0] trans_id;
    } wb_port_t;
endpackage

module lsu_multi_outstanding
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_W            = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_ex_i,
    input  fu_op_t          ls_operator_i,
    input  logic [ID_W-1:0] trans_id_i,
    input  logic [31:0]     ls_addr_i,
    input  logic [31:0]     store_data_i,
    input  logic            alu_vld_i,
    output logic            ls_rdy_o,
    output wb_port_t        ls_wb_port_o,
    output logic            ls_exc_vld_o,
    output logic [ID_W-1:0] ls_exc_id_o,
    output logic [31:0]     ls_exc_addr_o,
    output logic            data_req_o,
    output logic [31:0]     data_addr_o,
    output logic            data_we_o,
    output logic [3:0]      data_be_o,
    output logic [31:0]     data_wdata_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic [31:0]     data_rdata_i,
    input  logic            data_err_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_ld_cnt_o,
    output logic [31:0]     perf_st_cnt_o,
    output logic [31:0]     perf_stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic op_is_store(fu_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic op_misaligned(fu_op_t op, logic [1:0] off);
        case (op)
            LH, LHU, SH: return off[0];
            LW, SW:      return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(fu_op_t op, logic [1:0] off);
        logic [3:0] base;
        case (op)
            LB, LBU, SB: base = 4'b0001;
            LH, LHU, SH: base = 4'b0011;
            default:     base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] store_lanes(fu_op_t op, logic [31:0] d);
        case (op)
            SB:      return {4{d[7:0]}};
            SH:      return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(fu_op_t op, logic [31:0] rdata, logic [1:0] off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = rdata >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (op)
            LB:      return 32'(b);
            LH:      return 32'(h);
            LBU:     return {24'b0, sh[7:0]};
            LHU:     return {16'b0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    logic            req_vld_q, req_mis_q;
    fu_op_t          req_op_q;
    logic [ID_W-1:0] req_id_q;
    logic [31:0]     req_addr_q, req_wdata_q;

    logic [ID_W-1:0]            fifo_id_q   [MAX_OUTSTANDING];
    fu_op_t                     fifo_op_q   [MAX_OUTSTANDING];
    logic [31:0]                fifo_addr_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_sq_q;
    logic [PTR_W-1:0]           wptr_q, rptr_q;
    logic [CNT_W-1:0]           cnt_q;

    logic             push, pop, rsp_ok, rsp_err, mis_report, accept;
    logic             slot_free, fifo_space;
    logic [CNT_W:0]   cnt_with_push;

    assign data_req_o    = req_vld_q && !req_mis_q;
    assign push          = data_req_o && data_gnt_i;
    assign pop           = data_rvalid_i && (cnt_q != '0);
    assign rsp_ok        = pop && !fifo_sq_q[rptr_q] && !data_err_i;
    assign rsp_err       = pop && !fifo_sq_q[rptr_q] && data_err_i;
    // A bus error wins the exception port; the misalign report waits a cycle.
    assign mis_report    = req_vld_q && req_mis_q && !rsp_err && !flush_ex_i;
    assign slot_free     = !req_vld_q || push || mis_report;
    assign cnt_with_push = {1'b0, cnt_q} + (CNT_W + 1)'(push);
    assign fifo_space    = cnt_with_push < (CNT_W + 1)'(MAX_OUTSTANDING);
    assign ls_rdy_o      = !flush_ex_i && slot_free && fifo_space;
    assign accept        = alu_vld_i && ls_rdy_o;

    always_comb begin
        data_addr_o           = '0;
        data_we_o             = 1'b0;
        data_be_o             = '0;
        data_wdata_o          = '0;
        ls_wb_port_o          = '0;
        ls_exc_vld_o          = 1'b0;
        ls_exc_id_o           = '0;
        ls_exc_addr_o         = '0;
        if (data_req_o) begin
            data_addr_o  = {req_addr_q[31:2], 2'b00};
            data_we_o    = op_is_store(req_op_q);
            data_be_o    = byte_en(req_op_q, req_addr_q[1:0]);
            data_wdata_o = op_is_store(req_op_q) ? store_lanes(req_op_q, req_wdata_q) : '0;
        end
        if (rsp_ok) begin
            ls_wb_port_o.wb_vld   = 1'b1;
            ls_wb_port_o.trans_id = WB_ID_W'(fifo_id_q[rptr_q]);
            ls_wb_port_o.wb_data  = op_is_store(fifo_op_q[rptr_q]) ? '0 :
                load_extend(fifo_op_q[rptr_q], data_rdata_i, fifo_addr_q[rptr_q][1:0]);
        end
        if (rsp_err) begin
            ls_exc_vld_o  = 1'b1;
            ls_exc_id_o   = fifo_id_q[rptr_q];
            ls_exc_addr_o = fifo_addr_q[rptr_q];
        end else if (mis_report) begin
            ls_exc_vld_o  = 1'b1;
            ls_exc_id_o   = req_id_q;
            ls_exc_addr_o = req_addr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_vld_q <= 1'b0;
            req_mis_q <= 1'b0;
            fifo_sq_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (flush_ex_i) begin
                req_vld_q <= 1'b0;
            end else if (accept) begin
                req_vld_q <= 1'b1;
                req_mis_q <= op_misaligned(ls_operator_i, ls_addr_i[1:0]);
            end else if (push || mis_report) begin
                req_vld_q <= 1'b0;
            end
            if (flush_ex_i) fifo_sq_q <= '1;
            if (push) begin
                fifo_sq_q[wptr_q] <= flush_ex_i;
                wptr_q            <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload registers carry no reset; their valid bits qualify every use.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_op_q    <= ls_operator_i;
            req_id_q    <= trans_id_i;
            req_addr_q  <= ls_addr_i;
            req_wdata_q <= store_data_i;
        end
        if (push) begin
            fifo_id_q[wptr_q]   <= req_id_q;
            fifo_op_q[wptr_q]   <= req_op_q;
            fifo_addr_q[wptr_q] <= req_addr_q;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_ld_cnt_o    <= '0;
            perf_st_cnt_o    <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (rsp_ok && !op_is_store(fifo_op_q[rptr_q])) perf_ld_cnt_o <= perf_ld_cnt_o + 1'b1;
            if (rsp_ok && op_is_store(fifo_op_q[rptr_q]))  perf_st_cnt_o <= perf_st_cnt_o + 1'b1;
            if (alu_vld_i && !ls_rdy_o) perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_multi_outstanding.sv
// Directed bench for lsu_multi_outstanding (default parameters, perf counters disabled).
module tb_lsu_multi_outstanding;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_ex_i;
    fu_op_t      ls_operator_i;
    logic [4:0]  trans_id_i;
    logic [31:0] ls_addr_i, store_data_i;
    logic        alu_vld_i, ls_rdy_o;
    wb_port_t    ls_wb_port_o;
    logic        ls_exc_vld_o;
    logic [4:0]  ls_exc_id_o;
    logic [31:0] ls_exc_addr_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    lsu_multi_outstanding dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_ex_i(flush_ex_i),
        .ls_operator_i(ls_operator_i), .trans_id_i(trans_id_i), .ls_addr_i(ls_addr_i),
        .store_data_i(store_data_i), .alu_vld_i(alu_vld_i), .ls_rdy_o(ls_rdy_o),
        .ls_wb_port_o(ls_wb_port_o), .ls_exc_vld_o(ls_exc_vld_o), .ls_exc_id_o(ls_exc_id_o),
        .ls_exc_addr_o(ls_exc_addr_o), .data_req_o(data_req_o), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_err_i(data_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input fu_op_t op, input logic [4:0] id, input logic [31:0] addr,
                         input logic [31:0] wd);
        alu_vld_i     = 1'b1;
        ls_operator_i = op;
        trans_id_i    = id;
        ls_addr_i     = addr;
        store_data_i  = wd;
    endtask

    // One access: accept, immediate grant, then a clean response.
    task automatic single(input string tag, input fu_op_t op, input logic [4:0] id,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data);
        logic st;
        st = op inside {SB, SH, SW};
        issue(op, id, addr, wd);
        settle();
        check({tag, ".rdy"}, ls_rdy_o, 1);
        tick();
        alu_vld_i  = 1'b0;
        data_gnt_i = 1'b1;
        settle();
        check({tag, ".req"}, data_req_o, 1);
        check({tag, ".addr"}, data_addr_o, {addr[31:2], 2'b00});
        check({tag, ".be"}, data_be_o, exp_be);
        check({tag, ".we"}, data_we_o, st);
        check({tag, ".wdata"}, data_wdata_o, exp_wdata);
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        settle();
        check({tag, ".wb_vld"}, ls_wb_port_o.wb_vld, 1);
        check({tag, ".wb_data"}, ls_wb_port_o.wb_data, exp_data);
        check({tag, ".wb_id"}, ls_wb_port_o.trans_id, id);
        tick();
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; flush_ex_i = 1'b0; ls_operator_i = LB; trans_id_i = '0;
        ls_addr_i = '0; store_data_i = '0; alu_vld_i = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        #2;
        check("rst.rdy", ls_rdy_o, 1);
        check("rst.req", data_req_o, 0);
        check("rst.addr", data_addr_o, 0);
        check("rst.wb_vld", ls_wb_port_o.wb_vld, 0);
        check("rst.exc", ls_exc_vld_o, 0);
        #10 rst_i = 1'b0;
        tick();

        single("lb",  LB,  5'd1, 32'h1003, 32'h0,        32'h80AA5511, 4'b1000, 32'h0,        32'hFFFFFF80);
        single("sh",  SH,  5'd2, 32'h2002, 32'h0000BEEF, 32'h12345678, 4'b1100, 32'hBEEFBEEF, 32'h0);
        single("lbu", LBU, 5'd3, 32'h1001, 32'h0,        32'h80AA5511, 4'b0010, 32'h0,        32'h00000055);
        single("lh",  LH,  5'd4, 32'h1002, 32'h0,        32'h80AA5511, 4'b1100, 32'h0,        32'hFFFF80AA);
        single("lhu", LHU, 5'd6, 32'h1002, 32'h0,        32'h80AA5511, 4'b1100, 32'h0,        32'h000080AA);
        single("sb",  SB,  5'd5, 32'h2001, 32'h000000A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0);
        single("lw",  LW,  5'd7, 32'h1004, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF);

        // Three back-to-back loads against a two-deep FIFO.
        data_gnt_i = 1'b1;
        issue(LW, 5'd1, 32'h100, 0); settle(); check("b2b.rdy1", ls_rdy_o, 1); tick();
        issue(LW, 5'd2, 32'h104, 0); settle(); check("b2b.rdy2", ls_rdy_o, 1); tick();
        issue(LW, 5'd3, 32'h108, 0); settle(); check("b2b.full", ls_rdy_o, 0); tick();
        settle(); check("b2b.full2", ls_rdy_o, 0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111; settle();
        check("b2b.wb1_id", ls_wb_port_o.trans_id, 1);
        check("b2b.wb1_data", ls_wb_port_o.wb_data, 32'h11111111);
        check("b2b.rdy_pop", ls_rdy_o, 0);
        tick();
        data_rvalid_i = 1'b0; settle(); check("b2b.rdy_back", ls_rdy_o, 1); tick();
        alu_vld_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h22222222; settle();
        check("b2b.req3_addr", data_addr_o, 32'h108);
        check("b2b.wb2_id", ls_wb_port_o.trans_id, 2);
        tick();
        data_gnt_i = 1'b0; data_rdata_i = 32'h33333333; settle();
        check("b2b.wb3_vld", ls_wb_port_o.wb_vld, 1);
        check("b2b.wb3_id", ls_wb_port_o.trans_id, 3);
        check("b2b.wb3_data", ls_wb_port_o.wb_data, 32'h33333333);
        tick();
        data_rvalid_i = 1'b0;

        // Misaligned word load.
        issue(LW, 5'd4, 32'h3001, 0); tick();
        alu_vld_i = 1'b0; settle();
        check("mis.req", data_req_o, 0);
        check("mis.exc", ls_exc_vld_o, 1);
        check("mis.id", ls_exc_id_o, 4);
        check("mis.addr", ls_exc_addr_o, 32'h3001);
        check("mis.rdy", ls_rdy_o, 1);
        tick(); check("mis.exc_end", ls_exc_vld_o, 0);

        // Flush with two loads in flight.
        data_gnt_i = 1'b1;
        issue(LW, 5'd5, 32'h500, 0); tick();
        issue(LW, 5'd6, 32'h504, 0); tick();
        alu_vld_i = 1'b0; tick();
        data_gnt_i = 1'b0;
        flush_ex_i = 1'b1; issue(LW, 5'd9, 32'h600, 0); settle();
        check("fl.rdy", ls_rdy_o, 0);
        tick();
        flush_ex_i = 1'b0; alu_vld_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE0000 + i; settle();
            check("fl.wb_vld", ls_wb_port_o.wb_vld, 0);
            check("fl.exc", ls_exc_vld_o, 0);
            tick();
        end
        data_rvalid_i = 1'b0;

        // Bus error on a load at offset 2.
        issue(LHU, 5'd7, 32'h4002, 0); tick();
        alu_vld_i = 1'b0; data_gnt_i = 1'b1; tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_err_i = 1'b1; settle();
        check("err.wb_vld", ls_wb_port_o.wb_vld, 0);
        check("err.exc", ls_exc_vld_o, 1);
        check("err.id", ls_exc_id_o, 7);
        check("err.addr", ls_exc_addr_o, 32'h4002);
        tick();
        data_rvalid_i = 1'b0; data_err_i = 1'b0;

        // Bus error colliding with a pending misalign report.
        issue(LW, 5'd8, 32'h5000, 0); tick();
        data_gnt_i = 1'b1; issue(LH, 5'd9, 32'h5001, 0); tick();
        alu_vld_i = 1'b0; data_gnt_i = 1'b0;
        data_rvalid_i = 1'b1; data_err_i = 1'b1; settle();
        check("col.id1", ls_exc_id_o, 8);
        check("col.addr1", ls_exc_addr_o, 32'h5000);
        check("col.rdy", ls_rdy_o, 0);
        tick();
        data_rvalid_i = 1'b0; data_err_i = 1'b0; settle();
        check("col.exc2", ls_exc_vld_o, 1);
        check("col.id2", ls_exc_id_o, 9);
        check("col.addr2", ls_exc_addr_o, 32'h5001);
        tick();
        check("col.exc_end", ls_exc_vld_o, 0);
        check("col.rdy_end", ls_rdy_o, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_multi_outstanding.md
Name: lsu_multi_outstanding

Overview:
Parametrised next-generation load/store unit between the execute stage and the OBI-style data bus.
- Keeps up to MAX_OUTSTANDING bus transactions in flight.
- Performs byte-lane alignment and store-data replication for sub-word accesses.
- Detects misaligned accesses and reports them as exceptions.
- Drops responses belonging to flushed instructions.
- Writes results back through the standard wb_port_t port.

Parameters:
MAX_OUTSTANDING, 2, depth of the pending-response FIFO (1..8).
ID_W, 5, width of the trans_id tag.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_ex_i  in  1  squash all not-yet-written-back work
ls_operator_i  in  fu_op_t  LB/LH/LW/LBU/LHU/SB/SH/SW
trans_id_i  in  ID_W  instruction tag
ls_addr_i  in  32  byte address
store_data_i  in  32  store data (LSBs significant)
alu_vld_i  in  1  request valid
ls_rdy_o  out  1  request accepted when alu_vld_i && ls_rdy_o
ls_wb_port_o  out  wb_port_t  completion: wb_vld, wb_data, trans_id
ls_exc_vld_o  out  1  one-cycle misalign/bus-error pulse
ls_exc_id_o  out  ID_W  tag of excepting instruction
ls_exc_addr_o  out  32  faulting byte address
data_req_o  out  1  bus request
data_addr_o  out  32  word address {addr[31:2],2'b00}
data_we_o  out  1  1 = store
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-replicated store data
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  response valid (loads and stores)
data_rdata_i  in  32  read data
data_err_i  in  1  response error

Behaviour:
- Reset (rst_i high, async): request register empty, FIFO empty, squash bits clear. All outputs 0, except ls_rdy_o = 1.
- Request register: holds op, id, addr, wdata, misalign flag.
  - Loaded on accept; held stable while data_req_o && !data_gnt_i.
- Misalignment is checked at accept:
  - LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - A misaligned entry never asserts data_req_o.
  - Next cycle: ls_exc_vld_o = 1 with its id and addr; entry freed same cycle.
- Aligned entry:
  - data_req_o = 1 and data_we_o = store.
  - data_be_o = base_be << addr[1:0], with base_be = 0001 byte, 0011 half, 1111 word.
  - data_wdata_o: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
- On data_req_o && data_gnt_i: push {id, op, addr[1:0], squash = flush_ex_i} into FIFO; request register frees.
- ls_rdy_o = !flush_ex_i && slot_free && fifo_space, where:
  - slot_free = empty || granted-this-cycle || misalign-reporting-this-cycle.
  - fifo_space = (count + push_now) < MAX_OUTSTANDING.
  - Pop is deliberately excluded, so there is no rdata-to-rdy path.
- Back-to-back accept is possible (1 transaction/cycle) while the FIFO has room.
- Response path, on data_rvalid_i: pop FIFO head, then:
  - Head not squashed, !data_err_i: wb_vld = 1, trans_id = head id.
    - wb_data for stores = 0.
    - wb_data for loads = (rdata >> 8*offset), then sign-extended (LB/LH), zero-extended (LBU/LHU), or passed through (LW).
  - Head not squashed, data_err_i: wb_vld = 0; ls_exc_vld_o = 1 with head id, ls_exc_addr_o = word addr | offset.
  - Head squashed: pop silently, no outputs.
  - data_rvalid_i with an empty FIFO: ignored, no state change.
- Combinational timing: wb outputs are driven in the rvalid cycle; all else is 0.
- Exception collision: a bus error and a misalign report in the same cycle → the bus error is reported. The misalign report is held (entry not freed) and reported on the next cycle.
- Flush (flush_ex_i = 1):
  - Clears the ungranted request register; the request is aborted the same cycle.
  - A request granted in the flush cycle is still pushed, with squash = 1.
  - Sets squash on all FIFO entries; counts are unchanged so in-flight responses drain.
  - No accept in the flush cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance (wrap modulo MAX_OUTSTANDING).

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds outputs perf_ld_cnt_o[31:0], perf_st_cnt_o[31:0], perf_stall_cnt_o[31:0].
  - Load/store counts increment on non-squashed completions (wb_vld) of each type.
  - Stall count increments on cycles with alu_vld_i && !ls_rdy_o.
  - All reset to 0 and wrap at 2^32.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
1. LB addr 0x1003, rdata 0x80AA5511, gnt same cycle → be 1000, addr 0x1000, wb_data 0xFFFFFF80 at rvalid.
2. SH addr 0x2002, data 0x0000BEEF → be 1100, wdata 0xBEEFBEEF, we = 1; wb_vld with data 0 at rvalid.
3. MAX_OUTSTANDING = 2, three loads back-to-back, gnt immediate, rvalid withheld → ls_rdy_o low after second push; rises once the first rvalid is popped; responses retire in order, ids 1, 2, 3.
4. LW addr 0x3001 → no data_req_o; ls_exc_vld_o next cycle with addr 0x3001 and its id; ls_rdy_o stays 1.
5. Two loads outstanding, flush_ex_i pulse, then two rvalids → no wb_vld, no exception; FIFO empty afterwards.
6. rvalid with data_err_i on load id 7, offset 2, word address 0x4000 → wb_vld = 0, ls_exc_vld_o = 1, ls_exc_id_o = 7, ls_exc_addr_o = 0x4002.
